inst_fetch_mem: RTL and testbench
=================================

Name: inst_fetch_mem

Overview:
Parametrised, synchronous, byte-addressed instruction memory with a valid/ready fetch handshake and a byte-wide programming port. It sits between the PC/fetch stage and decode, and returns one little-endian 32-bit instruction per accepted request. It detects misaligned and out-of-range fetches, supports pipeline flush, and counts accepted fetches.

Parameters:
ADDR_W, 64, width of fetch and program addresses
DEPTH_BYTES, 256, memory size in bytes; must be a multiple of 4 and a power of 2
ALIGN_CHECK, 1, 1 = flag fetches with addr[1:0] != 0; 0 = ignore alignment

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  fetch request valid
req_ready  output  1  block can accept a fetch this cycle
req_addr  input  ADDR_W  byte address of the instruction
resp_valid  output  1  resp_inst/resp_err hold a valid result
resp_ready  input  1  consumer accepts the response
resp_inst  output  32  {mem[a+3], mem[a+2], mem[a+1], mem[a]}
resp_err  output  2  bit0 = misaligned, bit1 = out of range
flush  input  1  discard the held response
prog_en  input  1  byte write enable
prog_addr  input  ADDR_W  byte write address
prog_data  input  8  byte write data
fetch_count  output  32  number of accepted fetches

Behaviour:
- Reset (clk edge with reset=1) clears resp_valid, resp_inst, resp_err and fetch_count to 0.
- Memory array contents are not reset. Simulation initialises them to 0.
- req_ready = !prog_en && (!resp_valid || resp_ready). The ready path is combinational.
- Accept: req_valid && req_ready at a clk edge. Latency is 1 cycle: resp_valid=1 after that edge, with the result for req_addr.
- Two states, EMPTY (resp_valid=0) and FULL (resp_valid=1):
  - EMPTY to FULL on accept.
  - FULL to EMPTY on resp_ready with no new accept.
  - FULL to FULL on resp_ready plus accept. This gives back-to-back throughput of 1 per cycle.
- While FULL and resp_ready=0, resp_inst and resp_err hold stable.
- Out of range: req_addr > DEPTH_BYTES-4, using the full ADDR_W compare with no truncation. Result is resp_err[1]=1 and resp_inst=32'h00000013 (NOP).
- Misaligned (ALIGN_CHECK=1 and req_addr[1:0] != 0): resp_err[0]=1 and resp_inst=32'h00000013.
- Both error conditions may set together. Any error forces the NOP.
- Error responses still complete the handshake and increment fetch_count.
- fetch_count increments by 1 per accept and wraps from 32'hFFFFFFFF to 0.
- Programming:
  - When prog_en=1, mem[prog_addr] <= prog_data at the clk edge.
  - Writes with prog_addr >= DEPTH_BYTES are ignored.
  - No fetch is accepted while prog_en=1, so no read/write collision is possible.
  - An already-held response is unaffected by programming.
- Flush: flush=1 forces resp_valid to 0 at the next edge.
  - Flush has priority over a simultaneous accept. The request is dropped and fetch_count is not incremented.
  - flush and req_ready are independent; the upstream stage must not present a request it wants kept while asserting flush.
- Reset has priority over flush, prog_en and accept.
  - Reset mid-transaction drops the held response.
  - A prog write in the same cycle as reset is not performed.
- Address arithmetic: a+1..a+3 are computed only for in-range aligned addresses, so no wrap-around reads occur.

Test Plan:
- Program bytes 0..7 = 33 05 D6 00 B3 02 73 00. Fetch addr 0 then 4 back-to-back with resp_ready=1 -> resp_inst 32'h00D60533, then 32'h007302B3, on consecutive cycles; resp_err=0; fetch_count=2.
- Fetch addr 0 with resp_ready=0 for 3 cycles -> resp_valid=1 and resp_inst stable, req_ready=0; release -> next request accepted in the same cycle.
- Fetch addr 2, then addr DEPTH_BYTES (256), then addr 64'hFFFF_FFFF_FFFF_FFFC -> resp_err=01, 10, 10 respectively; resp_inst=32'h00000013 for all three.
- Hold prog_en=1 writing 0xAA to addr 8 while req_valid=1 -> req_ready=0 with no accept; then fetch addr 8 -> resp_inst[7:0]=8'hAA.
- flush asserted in the same cycle as an accept -> resp_valid=0 next cycle; fetch_count unchanged.
- Assert reset while FULL with resp_ready=0 -> next cycle resp_valid=0, resp_inst=0, fetch_count=0.

Source files
------------

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem
// Byte-addressed instruction memory between the PC/fetch stage and decode.
// A fetch request is accepted with a valid/ready handshake. One cycle later
// the block returns one little-endian 32-bit instruction, held until the
// consumer takes it. A byte-wide programming port loads the memory.
//
// Parameters
//   ADDR_W      width of fetch and program addresses
//   DEPTH_BYTES memory size in bytes (multiple of 4, power of 2)
//   ALIGN_CHECK 1 = flag fetches with addr[1:0] != 0, 0 = ignore alignment
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     fetch request handshake
//   req_addr                byte address of the instruction
//   resp_valid/resp_ready   response handshake
//   resp_inst               {mem[a+3], mem[a+2], mem[a+1], mem[a]} or NOP on error
//   resp_err                bit0 = misaligned, bit1 = out of range
//   flush                   discard the held response (and any same-cycle request)
//   prog_en/addr/data       byte write port; blocks fetch acceptance while high
//   fetch_count             number of accepted fetches, wrapping at 2^32
module inst_fetch_mem #(
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 256,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_inst,
    output logic [1:0]        resp_err,
    input  logic              flush,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [31:0]       fetch_count
);

    localparam int                IDX_W          = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR     = ADDR_W'(DEPTH_BYTES);
    localparam logic [31:0]       NOP_INST       = 32'h0000_0013;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        resp_inst_q, resp_inst_d;
    logic [1:0]         resp_err_q, resp_err_d;
    logic [31:0]        fetch_count_q, fetch_count_d;

    logic [7:0]         mem_q [DEPTH_BYTES];

    logic               accept;
    logic               misaligned;
    logic               out_of_range;
    logic [1:0]         fetch_err;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        rd_word;
    logic [31:0]        fetch_inst;
    logic               prog_we;

    // The range compare uses the full address width, so a huge address never
    // aliases onto a valid word by truncation.
    always_comb begin
        misaligned   = (ALIGN_CHECK != 0) && (req_addr[1:0] != 2'b00);
        out_of_range = req_addr > LAST_WORD_ADDR;
        fetch_err    = {out_of_range, misaligned};
        rd_idx       = req_addr[IDX_W-1:0];
        // For an in-range address a+3 stays inside the array. For any other
        // address the bytes read here are replaced by the NOP below.
        rd_word      = {mem_q[rd_idx + IDX_W'(3)],
                        mem_q[rd_idx + IDX_W'(2)],
                        mem_q[rd_idx + IDX_W'(1)],
                        mem_q[rd_idx]};
        fetch_inst   = (fetch_err != 2'b00) ? NOP_INST : rd_word;
    end

    // A new request fits when the output slot is empty or is being drained
    // this cycle. Programming takes the memory, so fetches stall while it is active.
    always_comb begin
        req_ready = !prog_en && ((state_q == ST_EMPTY) || resp_ready);
        accept    = req_valid && req_ready;
    end

    // Flush beats a same-cycle accept, and the dropped request is not counted.
    // The held instruction/error bits are left untouched when no new
    // fetch is loaded, so they stay stable while the consumer stalls.
    always_comb begin
        state_d       = state_q;
        resp_inst_d   = resp_inst_q;
        resp_err_d    = resp_err_q;
        fetch_count_d = fetch_count_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d       = ST_FULL;
            resp_inst_d   = fetch_inst;
            resp_err_d    = fetch_err;
            fetch_count_d = fetch_count_q + 32'd1;
        end else if ((state_q == ST_FULL) && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            resp_inst_q   <= 32'd0;
            resp_err_q    <= 2'b00;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            resp_inst_q   <= resp_inst_d;
            resp_err_q    <= resp_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Writes outside the array are dropped, not wrapped, and a write in the
    // reset cycle is suppressed. The array itself is never cleared.
    assign prog_we = prog_en && !reset && (prog_addr < DEPTH_ADDR);

    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    assign resp_valid  = (state_q == ST_FULL);
    assign resp_inst   = resp_inst_q;
    assign resp_err    = resp_err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb_inst_fetch_mem
// Testbench for inst_fetch_mem with the default parameters (64-bit
// addresses, 256 bytes, alignment checking on). It runs a table of directed
// vectors, then fills the whole memory and applies random traffic. A
// behavioural reference model of the memory and the response slot checks
// the random traffic.
module tb_inst_fetch_mem;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [1:0]  resp_err;
    logic        flush;
    logic        prog_en;
    logic [63:0] prog_addr;
    logic [7:0]  prog_data;
    logic [31:0] fetch_count;

    inst_fetch_mem #(
        .ADDR_W      (64),
        .DEPTH_BYTES (DEPTH),
        .ALIGN_CHECK (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_inst   (resp_inst),
        .resp_err    (resp_err),
        .flush       (flush),
        .prog_en     (prog_en),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte array plus the state of the response slot.
    logic [7:0]  m_mem [DEPTH];
    bit          m_valid;
    logic [31:0] m_inst;
    logic [1:0]  m_err;
    logic [31:0] m_count;
    bit          m_ready;
    logic        ready_seen;

    typedef struct {
        bit          rst;
        bit          rv;
        logic [63:0] addr;
        bit          rr;
        bit          fl;
        bit          pe;
        logic [63:0] pa;
        logic [7:0]  pd;
        bit          e_ready;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [1:0]  e_err;
        logic [31:0] e_count;
        bit          chk_inst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(bit rst, bit rv, logic [63:0] addr, bit rr, bit fl,
                                 bit pe, logic [63:0] pa, logic [7:0] pd,
                                 bit e_ready, bit e_valid, logic [31:0] e_inst,
                                 logic [1:0] e_err, logic [31:0] e_count, bit chk_inst);
        vec_t v;
        v.rst = rst; v.rv = rv; v.addr = addr; v.rr = rr; v.fl = fl;
        v.pe = pe; v.pa = pa; v.pd = pd;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_inst = e_inst;
        v.e_err = e_err; v.e_count = e_count; v.chk_inst = chk_inst;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, samples req_ready before the edge, then
    // advances the reference model from the same inputs after the edge.
    task automatic applyStimulus(input bit rst, input bit rv, input logic [63:0] addr,
                                 input bit rr, input bit fl, input bit pe,
                                 input logic [63:0] pa, input logic [7:0] pd);
        int a;
        reset      = rst;
        req_valid  = rv;
        req_addr   = addr;
        resp_ready = rr;
        flush      = fl;
        prog_en    = pe;
        prog_addr  = pa;
        prog_data  = pd;
        #1;
        ready_seen = req_ready;
        m_ready    = !pe && (!m_valid || rr);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0;
            m_inst  = 32'd0;
            m_err   = 2'b00;
            m_count = 32'd0;
        end else begin
            if (pe && pa < 64'(DEPTH)) m_mem[int'(pa)] = pd;
            if (fl) begin
                m_valid = 0;
            end else if (rv && m_ready) begin
                m_err[1] = addr > 64'(DEPTH - 4);
                m_err[0] = (addr % 64'd4) != 64'd0;
                if (m_err != 2'b00) begin
                    m_inst = 32'h0000_0013;
                end else begin
                    a      = int'(addr);
                    m_inst = {m_mem[a + 3], m_mem[a + 2], m_mem[a + 1], m_mem[a]};
                end
                m_valid = 1;
                m_count = m_count + 32'd1;
            end else if (m_valid && rr) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " ready"}, 64'(ready_seen), 64'(m_ready));
        checkOutput({tag, " valid"}, 64'(resp_valid), 64'(m_valid));
        checkOutput({tag, " count"}, 64'(fetch_count), 64'(m_count));
        if (m_valid) begin
            checkOutput({tag, " inst"}, 64'(resp_inst), 64'(m_inst));
            checkOutput({tag, " err"}, 64'(resp_err), 64'(m_err));
        end
    endtask

    initial begin
        logic [7:0]  prog_bytes [12];
        logic [63:0] addr;
        bit          rv, rr, fl, pe, rst;
        logic [63:0] pa;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_valid = 0; m_inst = 0; m_err = 0; m_count = 0;
        reset = 1'b1; req_valid = 0; req_addr = 0; resp_ready = 0;
        flush = 0; prog_en = 0; prog_addr = 0; prog_data = 0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset valid", 64'(resp_valid), 64'd0);
        checkOutput("reset inst", 64'(resp_inst), 64'd0);
        checkOutput("reset err", 64'(resp_err), 64'd0);
        checkOutput("reset count", 64'(fetch_count), 64'd0);

        prog_bytes = '{8'h33, 8'h05, 8'hD6, 8'h00, 8'hB3, 8'h02, 8'h73, 8'h00,
                       8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 12; i++)
            tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 64'(i), prog_bytes[i], 0, 0, 0, 0, 0, 0));
        // back-to-back fetches
        tbl.push_back(mkv(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h00D60533, 2'b00, 1, 1));
        tbl.push_back(mkv(0, 1, 4, 1, 0, 0, 0, 0, 1, 1, 32'h007302B3, 2'b00, 2, 1));
        tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0));
        // stall for three cycles, then release
        tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h00D60533, 2'b00, 3, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mkv(0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 32'h00D60533, 2'b00, 3, 1));
        tbl.push_back(mkv(0, 1, 4, 1, 0, 0, 0, 0, 1, 1, 32'h007302B3, 2'b00, 4, 1));
        // error responses
        tbl.push_back(mkv(0, 1, 2, 1, 0, 0, 0, 0, 1, 1, 32'h13, 2'b01, 5, 1));
        tbl.push_back(mkv(0, 1, 256, 1, 0, 0, 0, 0, 1, 1, 32'h13, 2'b10, 6, 1));
        tbl.push_back(mkv(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 0, 1, 1, 32'h13, 2'b10, 7, 1));
        tbl.push_back(mkv(0, 1, 255, 1, 0, 0, 0, 0, 1, 1, 32'h13, 2'b11, 8, 1));
        tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8, 0));
        // programming blocks a pending request
        tbl.push_back(mkv(0, 1, 8, 1, 0, 1, 8, 8'hAA, 0, 0, 0, 0, 8, 0));
        tbl.push_back(mkv(0, 1, 8, 1, 0, 0, 0, 0, 1, 1, 32'h443322AA, 2'b00, 9, 1));
        // out-of-range write must not alias onto byte 8
        tbl.push_back(mkv(0, 0, 0, 1, 0, 1, 264, 8'h99, 0, 0, 0, 0, 9, 0));
        tbl.push_back(mkv(0, 1, 8, 1, 0, 0, 0, 0, 1, 1, 32'h443322AA, 2'b00, 10, 1));
        // programming under a held response leaves it alone
        tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 8, 8'h55, 0, 1, 32'h443322AA, 2'b00, 10, 1));
        tbl.push_back(mkv(0, 1, 8, 1, 0, 0, 0, 0, 1, 1, 32'h44332255, 2'b00, 11, 1));
        // flush with a simultaneous accept
        tbl.push_back(mkv(0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 11, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 11, 0));
        // flush of a stalled response
        tbl.push_back(mkv(0, 1, 4, 0, 0, 0, 0, 0, 1, 1, 32'h007302B3, 2'b00, 12, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 12, 0));
        // reset while full, with a write in the reset cycle
        tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h00D60533, 2'b00, 13, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 8'hFF, 0, 0, 32'h0, 2'b00, 0, 1));
        tbl.push_back(mkv(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h00D60533, 2'b00, 1, 1));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].rv, tbl[i].addr, tbl[i].rr, tbl[i].fl,
                          tbl[i].pe, tbl[i].pa, tbl[i].pd);
            checkOutput($sformatf("v%0d ready", i), 64'(ready_seen), 64'(tbl[i].e_ready));
            checkOutput($sformatf("v%0d valid", i), 64'(resp_valid), 64'(tbl[i].e_valid));
            checkOutput($sformatf("v%0d count", i), 64'(fetch_count), 64'(tbl[i].e_count));
            if (tbl[i].chk_inst) begin
                checkOutput($sformatf("v%0d inst", i), 64'(resp_inst), 64'(tbl[i].e_inst));
                checkOutput($sformatf("v%0d err", i), 64'(resp_err), 64'(tbl[i].e_err));
            end
        end

        // Fill the whole memory with random bytes so every fetch is defined.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 0, 0, 1, 0, 1, 64'(i), 8'($urandom));
        applyStimulus(0, 1, 64'(DEPTH - 4), 1, 0, 0, 0, 0);
        checkModel("last word");

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            pe  = ($urandom_range(0, 7) == 0);
            pa  = 64'($urandom_range(0, 300));
            case ($urandom_range(0, 4))
                0:       addr = 64'($urandom_range(0, 63)) * 64'd4;
                1:       addr = 64'($urandom_range(0, 255));
                2:       addr = 64'($urandom_range(248, 264));
                3:       addr = {32'($urandom), 32'($urandom)};
                default: addr = 64'hFFFF_FFFF_FFFF_FFFC - 64'($urandom_range(0, 8));
            endcase
            applyStimulus(rst, rv, addr, rr, fl, pe, pa, 8'($urandom));
            checkModel($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
